round_robin_arbiter8: RTL and testbench

ROUND_ROBIN_ARBITER8 -- requirements
Module: round_robin_arbiter8

---
 rtl/round_robin_arbiter8_pkg.sv | 12 +
 rtl/round_robin_arbiter8_pri_enc8.sv | 21 ++
 rtl/round_robin_arbiter8.sv | 103 ++++++++++
 tb/tb_round_robin_arbiter8.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/round_robin_arbiter8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package round_robin_arbiter8_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/round_robin_arbiter8_pri_enc8.sv
// Lowest-index-first 8-to-3 priority encoder.
module pri_enc8
    import round_robin_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = |vec;
        for (int unsigned i = N_REQ; i > 0; i--) begin
            if (vec[i-1]) begin
                idx = IDX_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/round_robin_arbiter8.sv
// 8-way round-robin arbiter with done/drop/hold-limit release and registered outputs.
module round_robin_arbiter8
    import round_robin_arbiter8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_id,
    output logic             grant_valid,
    output logic             timeout
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] gid_d;
    logic             valid_d;
    logic             timeout_d;
    logic [N_REQ-1:0] grant_d;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_valid;
    logic [IDX_W-1:0]   winner;
    logic               at_limit;

    // Rotate req right by the pointer so the search starts at the pointer position.
    always_comb begin
        req_dbl = {req, req} >> ptr_q;
        req_rot = req_dbl[N_REQ-1:0];
    end

    pri_enc8 u_pri_enc8 (
        .vec   (req_rot),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign winner   = enc_idx + ptr_q;
    assign at_limit = (cnt_q == HOLD_LIMIT);

    // Next-state, pointer, hold counter and next output values.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gid_d     = grant_id;
        valid_d   = grant_valid;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && enc_valid) begin
                    state_d = BUSY;
                    gid_d   = winner;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (done || !req[grant_id] || at_limit) begin
                    state_d   = IDLE;
                    valid_d   = 1'b0;
                    ptr_d     = grant_id + 1'b1;
                    timeout_d = at_limit && !done;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        grant_d = valid_d ? (N_REQ'(1) << gid_d) : '0;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            grant       <= grant_d;
            grant_id    <= gid_d;
            grant_valid <= valid_d;
            timeout     <= timeout_d;
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter8.sv
// Directed self-checking bench for round_robin_arbiter8 (MAX_HOLD = 16).
module tb_round_robin_arbiter8;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int compared   = 0;
    int mismatched = 0;

    round_robin_arbiter8 #(.MAX_HOLD(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare all outputs; grant_id is only checked while a grant is expected.
    task automatic expect_out(input string tag, input logic v, input logic [2:0] id, input logic to);
        logic [12:0] obs, exp;
        logic [7:0]  g;
        g   = v ? (8'd1 << id) : 8'h00;
        exp = {g, v ? id : grant_id, v, to};
        obs = {grant, grant_id, grant_valid, timeout};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed grant=%h id=%0d valid=%b timeout=%b expected grant=%h id=%0d valid=%b timeout=%b",
                   tag, grant, grant_id, grant_valid, timeout, g, id, v, to);
        end
    endtask

    task automatic expect_id0(input string tag);
        compared++;
        assert (grant_id === 3'd0) else begin
            mismatched++;
            $error("FAIL %s observed grant_id=%0d expected 0", tag, grant_id);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; req = 8'h00; done = 1'b0;
        step(); step();
        expect_out("reset", 1'b0, 3'd0, 1'b0);
        expect_id0("reset_id");
        rst = 1'b0;

        // Full request vector, done each grant: 0..7 then wrap to 0.
        enable = 1'b1; req = 8'hFF;
        step(); expect_out("rr_first", 1'b1, 3'd0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            done = 1'b1; step(); expect_out("rr_gap", 1'b0, 3'd0, 1'b0);
            done = 1'b0; step(); expect_out("rr_seq", 1'b1, 3'(i), 1'b0);
        end
        done = 1'b1; step(); expect_out("rr_end", 1'b0, 3'd0, 1'b0);
        done = 1'b0;

        // Pointer 5 after grant to 4; wrap search picks 0, then 3.
        req = 8'h10;
        step(); expect_out("p5_g4", 1'b1, 3'd4, 1'b0);
        done = 1'b1; step(); expect_out("p5_rel", 1'b0, 3'd0, 1'b0);
        done = 1'b0; req = 8'b0000_1001;
        step(); expect_out("wrap_0", 1'b1, 3'd0, 1'b0);
        done = 1'b1; step(); expect_out("wrap_rel", 1'b0, 3'd0, 1'b0);
        done = 1'b0;
        step(); expect_out("wrap_3", 1'b1, 3'd3, 1'b0);
        done = 1'b1; step(); expect_out("wrap3_rel", 1'b0, 3'd0, 1'b0);
        done = 1'b0; req = 8'h00;
        step(); expect_out("idle_gap", 1'b0, 3'd0, 1'b0);

        // Hold limit: 16 held cycles, timeout pulse, regrant.
        req = 8'h04;
        step(); expect_out("hold_c1", 1'b1, 3'd2, 1'b0);
        for (int i = 2; i <= 16; i++) begin
            step(); expect_out("hold", 1'b1, 3'd2, 1'b0);
        end
        step(); expect_out("timeout", 1'b0, 3'd0, 1'b1);
        step(); expect_out("regrant", 1'b1, 3'd2, 1'b0);
        req = 8'h00;
        step(); expect_out("drop2", 1'b0, 3'd0, 1'b0);

        // Request drop by 6 releases without timeout; pointer moves to 7.
        req = 8'h40;
        step(); expect_out("g6", 1'b1, 3'd6, 1'b0);
        req = 8'h00;
        step(); expect_out("drop6", 1'b0, 3'd0, 1'b0);
        req = 8'h81;
        step(); expect_out("ptr7", 1'b1, 3'd7, 1'b0);
        done = 1'b1; step(); expect_out("ptr7_rel", 1'b0, 3'd0, 1'b0);
        req = 8'h00;
        step(); expect_out("done_idle", 1'b0, 3'd0, 1'b0);
        done = 1'b0;

        // Enable low keeps current grant and blocks the next one.
        req = 8'h02;
        step(); expect_out("en_g1", 1'b1, 3'd1, 1'b0);
        enable = 1'b0; req = 8'h03;
        step(); expect_out("en_hold_a", 1'b1, 3'd1, 1'b0);
        step(); expect_out("en_hold_b", 1'b1, 3'd1, 1'b0);
        done = 1'b1; step(); expect_out("en_rel", 1'b0, 3'd0, 1'b0);
        done = 1'b0;
        step(); expect_out("en_block_a", 1'b0, 3'd0, 1'b0);
        step(); expect_out("en_block_b", 1'b0, 3'd0, 1'b0);
        enable = 1'b1;
        step(); expect_out("en_resume", 1'b1, 3'd0, 1'b0);

        // done coinciding with the hold limit: no timeout.
        req = 8'h01;
        for (int i = 2; i <= 16; i++) begin
            step(); expect_out("lim_hold", 1'b1, 3'd0, 1'b0);
        end
        done = 1'b1; step(); expect_out("lim_done", 1'b0, 3'd0, 1'b0);
        done = 1'b0; req = 8'h20;
        step(); expect_out("g5", 1'b1, 3'd5, 1'b0);

        // Reset mid-grant, then pointer back at 0.
        rst = 1'b1; req = 8'hFF;
        step(); expect_out("rst_busy", 1'b0, 3'd0, 1'b0);
        expect_id0("rst_busy_id");
        rst = 1'b0;
        step(); expect_out("post_rst", 1'b1, 3'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
